// File: rtl/rotate_pkg.sv
// =============================================================================
//  Module      : rotate_pkg
//  Description : Shared definitions for the rotate_nco phase rotator.
//                Quadrant encoding, coefficient full-scale, quarter-wave
//                LUT contents and the rounding constant.
//  Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

package rotate_pkg;

   // Quadrant = top two phase bits
   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   // Full-scale coefficient magnitude, 2^(coef_w-1)-1
   function automatic int coef_fs(input int coef_w);
      return (1 << (coef_w - 1)) - 1;
   endfunction

   // Quarter-wave table entry: round(FS * cos|sin(addr*pi/2^(lut_addr_w+1))).
   // The angle never reaches pi/2, so both values are non-negative and
   // round-half-up is floor(v + 0.5).
   function automatic int lut_val(input int addr, input int lut_addr_w,
                                  input int coef_w, input bit want_sin);
      real ang;
      real v;
      ang = 3.14159265358979323846 * real'(addr) / real'(1 << (lut_addr_w + 1));
      v   = want_sin ? $sin(ang) : $cos(ang);
      return $rtoi(v * real'(coef_fs(coef_w)) + 0.5);
   endfunction

   // Half an output LSB before the arithmetic shift by coef_w-1
   function automatic int rnd_const(input int coef_w);
      return 1 << (coef_w - 2);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rotate_nco_if.sv
// =============================================================================
//  Module      : rotate_nco_if
//  Description : Sample stream bundle for rotate_nco: input stream
//                (in_valid/in_ready/in_i/in_q) and output stream
//                (out_valid/out_ready/out_i/out_q).
//                master : the environment (source of inputs, sink of outputs)
//                slave  : the rotator
//  Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

interface rotate_nco_if #(
   parameter int DATA_W = 16
) ();
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_i;
   logic signed [DATA_W-1:0] in_q;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_i;
   logic signed [DATA_W-1:0] out_q;

   modport master (
      output in_valid, in_i, in_q, out_ready,
      input  in_ready, out_valid, out_i, out_q
   );

   modport slave (
      input  in_valid, in_i, in_q, out_ready,
      output in_ready, out_valid, out_i, out_q
   );
endinterface

`default_nettype wire

// File: rtl/rotate_cs_lut.sv
// =============================================================================
//  Module      : rotate_cs_lut
//  Description : Registered quarter-wave cos/sin ROM with quadrant fold.
//                q0 (c,s)  q1 (-s,c)  q2 (-c,-s)  q3 (s,-c)
//  Ports       : clock    system clock
//                reset    synchronous active-low reset
//                en       pipeline advance (register holds when low)
//                quad     phase quadrant
//                addr     quarter-wave address
//                cos_val  folded cosine, registered
//                sin_val  folded sine, registered
//  Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module rotate_cs_lut
   import rotate_pkg::*;
#(
   parameter int LUT_ADDR_W = 8,
   parameter int COEF_W     = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     en,
   input  logic [1:0]               quad,
   input  logic [LUT_ADDR_W-1:0]    addr,
   output logic signed [COEF_W-1:0] cos_val,
   output logic signed [COEF_W-1:0] sin_val
);

   localparam int DEPTH = 1 << LUT_ADDR_W;

   logic signed [COEF_W-1:0] w_rom_c [DEPTH];
   logic signed [COEF_W-1:0] w_rom_s [DEPTH];
   logic signed [COEF_W-1:0] w_c;
   logic signed [COEF_W-1:0] w_s;
   logic signed [COEF_W-1:0] w_cos;
   logic signed [COEF_W-1:0] w_sin;

   // Table contents are elaboration-time constants
   for (genvar g = 0; g < DEPTH; g++) begin : g_rom
      assign w_rom_c[g] = COEF_W'(lut_val(g, LUT_ADDR_W, COEF_W, 1'b0));
      assign w_rom_s[g] = COEF_W'(lut_val(g, LUT_ADDR_W, COEF_W, 1'b1));
   end

   assign w_c = w_rom_c[addr];
   assign w_s = w_rom_s[addr];

   // Entries never exceed +FS, so negation cannot overflow
   always_comb begin
      w_cos = w_c;
      w_sin = w_s;
      case (quad)
         Q0: begin w_cos =  w_c; w_sin =  w_s; end
         Q1: begin w_cos = -w_s; w_sin =  w_c; end
         Q2: begin w_cos = -w_c; w_sin = -w_s; end
         Q3: begin w_cos =  w_s; w_sin = -w_c; end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cos_val <= '0;
         sin_val <= '0;
      end else if (en) begin
         cos_val <= w_cos;
         sin_val <= w_sin;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rotate_nco.sv
// =============================================================================
//  Module      : rotate_nco
//  Description : Streaming complex phase rotator,
//                out = in * exp(j*(acc + phase_off)), with integrated phase
//                accumulator, quarter-wave cos/sin LUT and valid/ready flow
//                control. Five-stage pipeline, latency 5 clocks.
//  Ports       : clock      system clock
//                reset      synchronous active-low reset
//                acc_clr    synchronous clear of the phase accumulator
//                freq       phase increment per accepted sample
//                phase_off  static phase offset
//                strm       sample streams (rotate_nco_if.slave)
//  Build macro : ROTATE_NCO_SAT_EN  saturate the rounded I/Q to DATA_W;
//                undefined: keep the low DATA_W bits (two's-complement wrap)
//  Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module rotate_nco
   import rotate_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int PHASE_W    = 16,
   parameter int LUT_ADDR_W = 8,
   parameter int COEF_W     = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               acc_clr,
   input  logic [PHASE_W-1:0] freq,
   input  logic [PHASE_W-1:0] phase_off,
   rotate_nco_if.slave        strm
);

   localparam int PROD_W  = DATA_W + COEF_W;
   localparam int SUM_W   = PROD_W + 1;
   localparam int TRUNC_W = PHASE_W - 2 - LUT_ADDR_W;
   localparam logic [SUM_W-1:0] C_RND = SUM_W'(rnd_const(COEF_W));

   // Single advance for the whole pipeline
   logic w_adv;
   logic w_accept;

   assign w_adv         = !strm.out_valid || strm.out_ready;
   assign w_accept      = strm.in_valid && w_adv;
   assign strm.in_ready = w_adv;

   // ---------------- phase accumulator ----------------
   logic [PHASE_W-1:0] r_acc;

   // Clear takes priority over the increment of a coincident sample
   always_ff @(posedge clock) begin
      if (!reset)        r_acc <= '0;
      else if (acc_clr)  r_acc <= '0;
      else if (w_accept) r_acc <= r_acc + freq;
   end

   // ---------------- S0: phase, capture ----------------
   logic                     r_v0;
   logic [PHASE_W-1:0]       r_ph0;
   logic signed [DATA_W-1:0] r_x0, r_y0;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_v0  <= 1'b0;
         r_ph0 <= '0;
         r_x0  <= '0;
         r_y0  <= '0;
      end else if (w_adv) begin
         r_v0  <= strm.in_valid;
         r_ph0 <= r_acc + phase_off;
         r_x0  <= strm.in_i;
         r_y0  <= strm.in_q;
      end
   end

   // Phase bits below the LUT address are intentionally dropped
   if (TRUNC_W > 0) begin : g_trunc
      logic w_unused_ph;
      assign w_unused_ph = ^r_ph0[TRUNC_W-1:0];
   end

   // ---------------- S1: quadrant / address ----------------
   logic                     r_v1;
   logic [1:0]               r_quad1;
   logic [LUT_ADDR_W-1:0]    r_addr1;
   logic signed [DATA_W-1:0] r_x1, r_y1;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_v1    <= 1'b0;
         r_quad1 <= '0;
         r_addr1 <= '0;
         r_x1    <= '0;
         r_y1    <= '0;
      end else if (w_adv) begin
         r_v1    <= r_v0;
         r_quad1 <= r_ph0[PHASE_W-1 -: 2];
         r_addr1 <= r_ph0[PHASE_W-3 -: LUT_ADDR_W];
         r_x1    <= r_x0;
         r_y1    <= r_y0;
      end
   end

   // ---------------- S2: LUT read ----------------
   logic                     r_v2;
   logic signed [DATA_W-1:0] r_x2, r_y2;
   logic signed [COEF_W-1:0] w_cos2, w_sin2;

   rotate_cs_lut #(
      .LUT_ADDR_W (LUT_ADDR_W),
      .COEF_W     (COEF_W)
   ) u_lut (
      .clock   (clock),
      .reset   (reset),
      .en      (w_adv),
      .quad    (r_quad1),
      .addr    (r_addr1),
      .cos_val (w_cos2),
      .sin_val (w_sin2)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_v2 <= 1'b0;
         r_x2 <= '0;
         r_y2 <= '0;
      end else if (w_adv) begin
         r_v2 <= r_v1;
         r_x2 <= r_x1;
         r_y2 <= r_y1;
      end
   end

   // ---------------- S3: products ----------------
   logic                     r_v3;
   logic signed [PROD_W-1:0] r_p_xc, r_p_ys, r_p_xs, r_p_yc;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_v3   <= 1'b0;
         r_p_xc <= '0;
         r_p_ys <= '0;
         r_p_xs <= '0;
         r_p_yc <= '0;
      end else if (w_adv) begin
         r_v3   <= r_v2;
         r_p_xc <= r_x2 * w_cos2;
         r_p_ys <= r_y2 * w_sin2;
         r_p_xs <= r_x2 * w_sin2;
         r_p_yc <= r_y2 * w_cos2;
      end
   end

   // ---------------- S4: combine, round, reduce ----------------
   logic signed [SUM_W-1:0]  w_sum_i, w_sum_q;
   logic signed [SUM_W-1:0]  w_rnd_i, w_rnd_q;
   logic signed [DATA_W-1:0] w_res_i, w_res_q;

   // One guard bit holds the sum of two full-scale products plus rounding
   assign w_sum_i = {r_p_xc[PROD_W-1], r_p_xc} - {r_p_ys[PROD_W-1], r_p_ys} + C_RND;
   assign w_sum_q = {r_p_xs[PROD_W-1], r_p_xs} + {r_p_yc[PROD_W-1], r_p_yc} + C_RND;
   assign w_rnd_i = w_sum_i >>> (COEF_W - 1);
   assign w_rnd_q = w_sum_q >>> (COEF_W - 1);

`ifdef ROTATE_NCO_SAT_EN
   localparam logic signed [SUM_W-1:0] C_MAX = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] C_MIN = ~C_MAX;

   assign w_res_i = (w_rnd_i > C_MAX) ? C_MAX[DATA_W-1:0] :
                    (w_rnd_i < C_MIN) ? C_MIN[DATA_W-1:0] : w_rnd_i[DATA_W-1:0];
   assign w_res_q = (w_rnd_q > C_MAX) ? C_MAX[DATA_W-1:0] :
                    (w_rnd_q < C_MIN) ? C_MIN[DATA_W-1:0] : w_rnd_q[DATA_W-1:0];
`else
   // Wrap build: upper bits are discarded on purpose
   logic w_unused_rnd;

   assign w_res_i      = w_rnd_i[DATA_W-1:0];
   assign w_res_q      = w_rnd_q[DATA_W-1:0];
   assign w_unused_rnd = ^{w_rnd_i[SUM_W-1:DATA_W], w_rnd_q[SUM_W-1:DATA_W]};
`endif

   logic                     r_v4;
   logic signed [DATA_W-1:0] r_out_i, r_out_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_v4    <= 1'b0;
         r_out_i <= '0;
         r_out_q <= '0;
      end else if (w_adv) begin
         r_v4    <= r_v3;
         r_out_i <= w_res_i;
         r_out_q <= w_res_q;
      end
   end

   assign strm.out_valid = r_v4;
   assign strm.out_i     = r_out_i;
   assign strm.out_q     = r_out_q;

endmodule

`default_nettype wire

// File: tb/tb_rotate_nco.sv
// =============================================================================
//  Module      : tb_rotate_nco
//  Description : Self-checking bench for rotate_nco (16/16/8/16 build).
//                Expected outputs are queued when a sample is accepted and
//                matched against the outputs the DUT hands over.
//  Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_rotate_nco;

   logic        clock = 1'b0;
   logic        reset;
   logic        acc_clr;
   logic [15:0] freq;
   logic [15:0] phase_off;

   rotate_nco_if #(.DATA_W(16)) strm ();

   rotate_nco #(
      .DATA_W     (16),
      .PHASE_W    (16),
      .LUT_ADDR_W (8),
      .COEF_W     (16)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .acc_clr   (acc_clr),
      .freq      (freq),
      .phase_off (phase_off),
      .strm      (strm)
   );

   always #5 clock = ~clock;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];
   logic [15:0] acc_m;

`ifdef ROTATE_NCO_SAT_EN
   localparam int SAT_Q = -32768;
`else
   localparam int SAT_Q = 19196;
`endif

   // Capture each handed-over output; the transfer happens at the next posedge
   always @(negedge clock) begin
      if (reset && strm.out_valid && strm.out_ready)
         obs_q.push_back({strm.out_i, strm.out_q});
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] pack(input int i, input int q);
      return {i[15:0], q[15:0]};
   endfunction

   // Reference rotator computed from the mathematical definition
   function automatic logic [31:0] model(input logic [15:0] ph,
                                         input logic signed [15:0] x,
                                         input logic signed [15:0] y);
      int     quad, addr;
      real    ang;
      longint c0, s0, c, s, si, sq;
      quad = int'(ph[15:14]);
      addr = int'(ph[13:6]);
      ang  = 3.14159265358979323846 * real'(addr) / 512.0;
      c0   = longint'($rtoi($cos(ang) * 32767.0 + 0.5));
      s0   = longint'($rtoi($sin(ang) * 32767.0 + 0.5));
      case (quad)
         0:       begin c =  c0; s =  s0; end
         1:       begin c = -s0; s =  c0; end
         2:       begin c = -c0; s = -s0; end
         default: begin c =  s0; s = -c0; end
      endcase
      si = (longint'(x) * c - longint'(y) * s + 64'sd16384) >>> 15;
      sq = (longint'(x) * s + longint'(y) * c + 64'sd16384) >>> 15;
`ifdef ROTATE_NCO_SAT_EN
      if (si > 32767)  si = 32767;
      if (si < -32768) si = -32768;
      if (sq > 32767)  sq = 32767;
      if (sq < -32768) sq = -32768;
`endif
      return {si[15:0], sq[15:0]};
   endfunction

   // Drive one sample until accepted; queue its expected output
   task automatic send(input logic signed [15:0] x, input logic signed [15:0] y,
                       input logic [15:0] f, input logic [15:0] off,
                       input logic clr, input logic [31:0] exp_v);
      int t;
      strm.in_valid = 1'b1;
      strm.in_i     = x;
      strm.in_q     = y;
      freq          = f;
      phase_off     = off;
      acc_clr       = clr;
      for (t = 0; t < 50; t++) begin
         @(negedge clock);
         if (strm.in_ready) break;
         @(posedge clock); #1;
      end
      checks++;
      if (t == 50) begin
         failures++;
         $display("FAIL send_accept got=in_ready_low want=accept");
      end else begin
         exp_q.push_back(exp_v);
         acc_m = clr ? 16'h0 : 16'(acc_m + f);
      end
      @(posedge clock); #1;
      strm.in_valid = 1'b0;
      acc_clr       = 1'b0;
   endtask

   task automatic pulse_clr();
      acc_clr = 1'b1;
      @(posedge clock); #1;
      acc_clr = 1'b0;
      acc_m   = 16'h0;
   endtask

   // Bounded wait for the outputs to catch up with the expectations
   task automatic wait_drain(input int extra);
      for (int t = 0; t < 100 && obs_q.size() < exp_q.size(); t++) @(posedge clock);
      repeat (extra) @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (strm.out_valid !== 1'b0 || strm.out_i !== 16'sd0 || strm.out_q !== 16'sd0) begin
         failures++;
         $display("FAIL reset_state got=v%0b (%0d,%0d) want=v0 (0,0)",
                  strm.out_valid, strm.out_i, strm.out_q);
      end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (strm.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got=%0b want=1", strm.in_ready);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_basic();
      logic [31:0] e, o;
      freq          = 16'h0;
      phase_off     = 16'h0;
      strm.in_i     = 16'sd1000;
      strm.in_q     = 16'sd0;
      strm.in_valid = 1'b1;
      exp_q.push_back(pack(1000, 0));
      for (int k = 1; k <= 5; k++) begin
         @(posedge clock); #1;
         strm.in_valid = 1'b0;
         @(negedge clock);
         checks++;
         if (strm.out_valid !== (k == 5)) begin
            failures++;
            $display("FAIL basic_latency clk=%0d got=%0b want=%0b", k, strm.out_valid, (k == 5));
         end
      end
      wait_drain(2);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL basic_data got=(%0d,%0d) want=(%0d,%0d)",
                     $signed(o[31:16]), $signed(o[15:0]), $signed(e[31:16]), $signed(e[15:0]));
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_phase_off();
      logic [31:0] e, o;
      send(16'sd1000, 16'sd500, 16'h0, 16'h4000, 1'b0, pack(-500, 1000));
      send(16'sd1000, 16'sd500, 16'h0, 16'h8000, 1'b0, pack(-1000, -500));
      wait_drain(2);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL phase_off_count got=%0d want=%0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL phase_off_data got=(%0d,%0d) want=(%0d,%0d)",
                     $signed(o[31:16]), $signed(o[15:0]), $signed(e[31:16]), $signed(e[15:0]));
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [31:0] e, o;
      pulse_clr();
      send(16'sd1000, 16'sd0, 16'h4000, 16'h0, 1'b0, pack(1000, 0));
      send(16'sd1000, 16'sd0, 16'h4000, 16'h0, 1'b0, pack(0, 1000));
      send(16'sd1000, 16'sd0, 16'h4000, 16'h0, 1'b0, pack(-1000, 0));
      send(16'sd1000, 16'sd0, 16'h4000, 16'h0, 1'b0, pack(0, -1000));
      send(16'sd1000, 16'sd0, 16'h4000, 16'h0, 1'b0, pack(1000, 0));
      pulse_clr();
      send(16'sd1000, 16'sd0, 16'h4000, 16'h0, 1'b0, pack(1000, 0));
      // clear coincident with a sample: sample sees old acc, acc ends at 0
      send(16'sd1000, 16'sd0, 16'h4000, 16'h0, 1'b1, pack(0, 1000));
      send(16'sd1000, 16'sd0, 16'h0,    16'h0, 1'b0, pack(1000, 0));
      wait_drain(2);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL b2b_data got=(%0d,%0d) want=(%0d,%0d)",
                     $signed(o[31:16]), $signed(o[15:0]), $signed(e[31:16]), $signed(e[15:0]));
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_saturation();
      logic [31:0] e, o;
      pulse_clr();
      send(-16'sd32768, -16'sd32768, 16'h0, 16'h2000, 1'b0, pack(0, SAT_Q));
      wait_drain(2);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL sat_count got=%0d want=%0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL sat_data got=(%0d,%0d) want=(%0d,%0d)",
                     $signed(o[31:16]), $signed(o[15:0]), $signed(e[31:16]), $signed(e[15:0]));
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_stall();
      logic [31:0]        e, o, held;
      logic signed [15:0] x, y;
      int                 sent;
      sent = 0;
      held = '0;
      pulse_clr();
      freq      = 16'h1000;
      phase_off = 16'h0;
      for (int cyc = 0; cyc < 60 && sent < 8; cyc++) begin
         x = 16'(1000 + 100 * sent);
         y = 16'(-300 * sent);
         strm.in_valid  = 1'b1;
         strm.in_i      = x;
         strm.in_q      = y;
         strm.out_ready = !(cyc >= 6 && cyc < 9);
         @(negedge clock);
         if (!strm.out_ready) begin
            checks++;
            if (strm.in_ready !== 1'b0 || strm.out_valid !== 1'b1) begin
               failures++;
               $display("FAIL stall_flags cyc=%0d got=rdy%0b vld%0b want=rdy0 vld1",
                        cyc, strm.in_ready, strm.out_valid);
            end
            if (cyc == 6) held = {strm.out_i, strm.out_q};
            else begin
               checks++;
               if ({strm.out_i, strm.out_q} !== held) begin
                  failures++;
                  $display("FAIL stall_hold cyc=%0d got=%h want=%h", cyc, {strm.out_i, strm.out_q}, held);
               end
            end
         end
         if (strm.in_ready) begin
            exp_q.push_back(model(16'(acc_m + phase_off), x, y));
            acc_m = 16'(acc_m + freq);
            sent++;
         end
         @(posedge clock); #1;
      end
      strm.in_valid  = 1'b0;
      strm.out_ready = 1'b1;
      // 8 * 0x1000 leaves the accumulator at half a turn
      send(16'sd1000, 16'sd0, 16'h0, 16'h0, 1'b0, pack(-1000, 0));
      wait_drain(3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL stall_count got=%0d want=%0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL stall_data got=(%0d,%0d) want=(%0d,%0d)",
                     $signed(o[31:16]), $signed(o[15:0]), $signed(e[31:16]), $signed(e[15:0]));
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid();
      logic [31:0] e, o;
      pulse_clr();
      send(16'sd1000, 16'sd0, 16'h4000, 16'h0, 1'b0, pack(1000, 0));
      send(16'sd1000, 16'sd0, 16'h4000, 16'h0, 1'b0, pack(0, 1000));
      send(16'sd1000, 16'sd0, 16'h4000, 16'h0, 1'b0, pack(-1000, 0));
      reset = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      checks++;
      if (strm.out_valid !== 1'b0 || strm.out_i !== 16'sd0 || strm.out_q !== 16'sd0) begin
         failures++;
         $display("FAIL midreset_state got=v%0b (%0d,%0d) want=v0 (0,0)",
                  strm.out_valid, strm.out_i, strm.out_q);
      end
      exp_q.delete();
      acc_m = 16'h0;
      send(16'sd1000, 16'sd0, 16'h0, 16'h0, 1'b0, pack(1000, 0));
      wait_drain(10);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL midreset_count got=%0d want=%0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL midreset_data got=(%0d,%0d) want=(%0d,%0d)",
                     $signed(o[31:16]), $signed(o[15:0]), $signed(e[31:16]), $signed(e[15:0]));
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      reset          = 1'b0;
      acc_clr        = 1'b0;
      freq           = 16'h0;
      phase_off      = 16'h0;
      strm.in_valid  = 1'b0;
      strm.in_i      = 16'sd0;
      strm.in_q      = 16'sd0;
      strm.out_ready = 1'b1;
      acc_m          = 16'h0;
      test_reset();
      test_basic();
      test_phase_off();
      test_back_to_back();
      test_saturation();
      test_stall();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
